// File: rtl/uart_pkg.sv
// Shared types and helpers for the framed UART receiver.
// State encoding, parity mode constants and the parity reduction used by the frame checker.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        DONE      = 3'd5,
        WAIT_IDLE = 3'd6
    } state_t;

    localparam int PARITY_NONE   = 0;
    localparam int PARITY_EVEN   = 1;
    localparam int PARITY_ODD    = 2;
    localparam int MAX_DATA_BITS = 9;

    // Callers zero-extend narrower data; the extra zeros do not change the XOR.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Purpose: 2-flop synchroniser for the serial pad plus optional 3-tap majority vote (UART_RX_MAJORITY_EN).
// Latency: rx_s lags the pad by 2 cycles; sample_bit is combinational on rx_s and its history.
// Backpressure: none; free-running line sampler.
module uart_rx_sampler (
    input  logic i_Clock,
    input  logic i_Rst_L,
    input  logic i_RX_Serial,
    output logic rx_s,
    output logic sample_bit
`ifdef UART_RX_MAJORITY_EN
    ,
    output logic disagree
`endif
);

    logic rx_meta;

    // Reset to 1 so a reset never looks like a start edge.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_RX_Serial;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic rx_d1;
    logic rx_d2;

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            rx_d1 <= 1'b1;
            rx_d2 <= 1'b1;
        end else begin
            rx_d1 <= rx_s;
            rx_d2 <= rx_d1;
        end
    end

    assign sample_bit = (rx_d2 & rx_d1) | (rx_d2 & rx_s) | (rx_d1 & rx_s);
    assign disagree   = !((rx_d2 == rx_d1) && (rx_d1 == rx_s));
`else
    assign sample_bit = rx_s;
`endif

endmodule

// File: rtl/uart_rx_framed.sv
// Purpose: parametrised UART receiver (5-9 data bits, none/even/odd parity, 1-2 stop bits) with error/break flags; UART_RX_MAJORITY_EN adds majority sampling and o_Noise.
// Latency: o_RX_DV one cycle after the last stop-bit sample (mid stop bit + ~3 cycles from the line edge).
// Backpressure: none; consumer must take o_RX_Byte on the o_RX_DV pulse (held until the next one).
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
`ifdef UART_RX_MAJORITY_EN
    output logic                 o_Noise,
`endif
    output logic                 o_Busy
);

    localparam int             CW         = $clog2(CLKS_PER_BIT);
    localparam int             IW         = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0]  CNT_MID    = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0]  CNT_MAX    = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0]  IDX_LAST   = IW'(DATA_BITS - 1);
    localparam logic           STOP_LAST  = (STOP_BITS == 2);
    localparam logic           HAS_PARITY = (PARITY_MODE != PARITY_NONE);

`ifndef SYNTHESIS
    initial begin
        if (DATA_BITS < 5 || DATA_BITS > 9) $error("uart_rx_framed: DATA_BITS=%0d out of range", DATA_BITS);
        if (PARITY_MODE < 0 || PARITY_MODE > 2) $error("uart_rx_framed: PARITY_MODE=%0d illegal", PARITY_MODE);
        if (STOP_BITS != 1 && STOP_BITS != 2) $error("uart_rx_framed: STOP_BITS=%0d illegal", STOP_BITS);
        if (CLKS_PER_BIT < 8) $error("uart_rx_framed: CLKS_PER_BIT=%0d too small", CLKS_PER_BIT);
    end
`endif

    state_t                state_q;
    state_t                state_d;
    logic [CW-1:0]         cnt_q;
    logic [IW-1:0]         idx_q;
    logic                  stop_idx_q;
    logic [DATA_BITS-1:0]  shreg_q;
    logic                  par_bit_q;
    logic                  fe_q;
    logic                  stop0_low_q;
    logic                  rx_s;
    logic                  sample_bit;
    logic                  mid_tick;
    logic                  bit_tick;
    logic                  last_stop;
    logic                  par_err_now;
    logic                  brk_now;

`ifdef UART_RX_MAJORITY_EN
    logic                  disagree;
    logic                  noise_q;

    uart_rx_sampler u_sampler (
        .i_Clock     (i_Clock),
        .i_Rst_L     (i_Rst_L),
        .i_RX_Serial (i_RX_Serial),
        .rx_s        (rx_s),
        .sample_bit  (sample_bit),
        .disagree    (disagree)
    );
`else
    uart_rx_sampler u_sampler (
        .i_Clock     (i_Clock),
        .i_Rst_L     (i_Rst_L),
        .i_RX_Serial (i_RX_Serial),
        .rx_s        (rx_s),
        .sample_bit  (sample_bit)
    );
`endif

    assign mid_tick  = (cnt_q == CNT_MID);
    assign bit_tick  = (cnt_q == CNT_MAX);
    assign last_stop = (stop_idx_q == STOP_LAST);

    // Frame verdicts evaluated on the final stop sample, committed with the DONE transition.
    assign par_err_now = HAS_PARITY &&
                         (par_bit_q != calc_parity(MAX_DATA_BITS'(shreg_q), PARITY_MODE));
    assign brk_now     = (shreg_q == '0) && !(HAS_PARITY && par_bit_q) &&
                         (stop_idx_q ? stop0_low_q : !sample_bit);

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!rx_s) state_d = START;
            START:     if (mid_tick) state_d = sample_bit ? IDLE : DATA;
            DATA:      if (bit_tick && idx_q == IDX_LAST) state_d = HAS_PARITY ? PARITY : STOP;
            PARITY:    if (bit_tick) state_d = STOP;
            STOP:      if (bit_tick && last_stop) state_d = DONE;
            DONE:      state_d = o_Frame_Err ? WAIT_IDLE : IDLE;
            WAIT_IDLE: if (rx_s) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        o_RX_DV = (state_q == DONE);
        o_Busy  = (state_q != IDLE);
`ifdef UART_RX_MAJORITY_EN
        o_Noise = (state_q == DONE) && noise_q;
`endif
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            stop_idx_q   <= 1'b0;
            shreg_q      <= '0;
            par_bit_q    <= 1'b0;
            fe_q         <= 1'b0;
            stop0_low_q  <= 1'b0;
            o_RX_Byte    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Break      <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            noise_q      <= 1'b0;
`endif
        end else begin
            cnt_q <= cnt_q + CW'(1);
            case (state_q)
                START: if (mid_tick) cnt_q <= '0;
                DATA: if (bit_tick) begin
                    cnt_q   <= '0;
                    shreg_q <= {sample_bit, shreg_q[DATA_BITS-1:1]};
                    idx_q   <= idx_q + IW'(1);
                end
                PARITY: if (bit_tick) begin
                    cnt_q     <= '0;
                    par_bit_q <= sample_bit;
                end
                STOP: if (bit_tick) begin
                    cnt_q      <= '0;
                    stop_idx_q <= ~stop_idx_q;
                    if (!sample_bit) fe_q <= 1'b1;
                    if (!stop_idx_q) stop0_low_q <= !sample_bit;
                    if (last_stop) begin
                        o_RX_Byte    <= shreg_q;
                        o_Parity_Err <= par_err_now;
                        o_Frame_Err  <= fe_q | !sample_bit;
                        o_Break      <= brk_now;
                    end
                end
                default: begin
                    // IDLE/DONE/WAIT_IDLE: rearm per-frame state for the next start.
                    cnt_q       <= '0;
                    idx_q       <= '0;
                    stop_idx_q  <= 1'b0;
                    fe_q        <= 1'b0;
                    stop0_low_q <= 1'b0;
                end
            endcase
`ifdef UART_RX_MAJORITY_EN
            if (state_q == IDLE) begin
                noise_q <= 1'b0;
            end else if (((state_q == START) && mid_tick) ||
                         (((state_q == DATA) || (state_q == PARITY) || (state_q == STOP)) && bit_tick)) begin
                noise_q <= noise_q | disagree;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed: an 8N1 instance and a 7E2 instance at 16 clocks per bit.
module tb_uart_rx_framed;

    localparam int CPB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_l;
    logic       ser_a, ser_b;
    logic       dv_a, perr_a, fe_a, brk_a, busy_a;
    logic [7:0] byte_a;
    logic       dv_b, perr_b, fe_b, brk_b, busy_b;
    logic [6:0] byte_b;
`ifdef UART_RX_MAJORITY_EN
    logic       noise_a, noise_b;
`endif

    uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .i_Clock      (clk),
        .i_Rst_L      (rst_l),
        .i_RX_Serial  (ser_a),
        .o_RX_DV      (dv_a),
        .o_RX_Byte    (byte_a),
        .o_Parity_Err (perr_a),
        .o_Frame_Err  (fe_a),
        .o_Break      (brk_a),
`ifdef UART_RX_MAJORITY_EN
        .o_Noise      (noise_a),
`endif
        .o_Busy       (busy_a)
    );

    uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u_7e2 (
        .i_Clock      (clk),
        .i_Rst_L      (rst_l),
        .i_RX_Serial  (ser_b),
        .o_RX_DV      (dv_b),
        .o_RX_Byte    (byte_b),
        .o_Parity_Err (perr_b),
        .o_Frame_Err  (fe_b),
        .o_Break      (brk_b),
`ifdef UART_RX_MAJORITY_EN
        .o_Noise      (noise_b),
`endif
        .o_Busy       (busy_b)
    );

    int checks   = 0;
    int failures = 0;

    int         dvn_a = 0, dvn_b = 0;
    logic [7:0] cap_byte_a;
    logic [6:0] cap_byte_b;
    logic [2:0] cap_flags_a, cap_flags_b;   // {parity, frame, break}
    logic [7:0] q_a[$];
`ifdef UART_RX_MAJORITY_EN
    logic       cap_noise_a;
`endif

    always @(negedge clk) begin
        if (dv_a === 1'b1) begin
            dvn_a       <= dvn_a + 1;
            cap_byte_a  <= byte_a;
            cap_flags_a <= {perr_a, fe_a, brk_a};
            q_a.push_back(byte_a);
`ifdef UART_RX_MAJORITY_EN
            cap_noise_a <= noise_a;
`endif
        end
        if (dv_b === 1'b1) begin
            dvn_b       <= dvn_b + 1;
            cap_byte_b  <= byte_b;
            cap_flags_b <= {perr_b, fe_b, brk_b};
        end
    end

    task automatic abit(input logic b);
        ser_a = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic aframe(input logic [7:0] d, input logic stop);
        abit(1'b0);
        for (int i = 0; i < 8; i++) abit(d[i]);
        abit(stop);
        ser_a = 1'b1;
    endtask

    task automatic bbit(input logic b);
        ser_b = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic bframe(input logic [6:0] d, input logic par, input logic stop2);
        bbit(1'b0);
        for (int i = 0; i < 7; i++) bbit(d[i]);
        bbit(par);
        bbit(1'b1);
        bbit(stop2);
        ser_b = 1'b1;
    endtask

    task automatic test_reset;
        rst_l = 1'b0;
        ser_a = 1'b1;
        ser_b = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (dv_a !== 1'b0) begin failures++; $display("FAIL reset_dv: got %b want 0", dv_a); end
        checks++; if (byte_a !== 8'h00) begin failures++; $display("FAIL reset_byte: got %h want 00", byte_a); end
        checks++; if ({perr_a, fe_a, brk_a} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", {perr_a, fe_a, brk_a}); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        checks++; if ({dv_b, byte_b, busy_b} !== 9'h000) begin failures++; $display("FAIL reset_b: got %h want 000", {dv_b, byte_b, busy_b}); end
        rst_l = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_8n1_basic;
        int n0 = dvn_a;
        aframe(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (dvn_a - n0 !== 1) begin failures++; $display("FAIL a5_dv_count: got %0d want 1", dvn_a - n0); end
        checks++; if (cap_byte_a !== 8'hA5) begin failures++; $display("FAIL a5_byte: got %h want a5", cap_byte_a); end
        checks++; if (cap_flags_a !== 3'b000) begin failures++; $display("FAIL a5_flags: got %b want 000", cap_flags_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL a5_busy: got %b want 0", busy_a); end
        checks++; if (byte_a !== 8'hA5) begin failures++; $display("FAIL a5_hold: got %h want a5", byte_a); end
`ifdef UART_RX_MAJORITY_EN
        checks++; if (cap_noise_a !== 1'b0) begin failures++; $display("FAIL a5_noise: got %b want 0", cap_noise_a); end
`endif
    endtask

    task automatic test_parity;
        int n0 = dvn_b;
        // 0x55 in 7 bits has four ones: even parity bit is 0.
        bframe(7'h55, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (dvn_b - n0 !== 1) begin failures++; $display("FAIL par_ok_count: got %0d want 1", dvn_b - n0); end
        checks++; if (cap_byte_b !== 7'h55) begin failures++; $display("FAIL par_ok_byte: got %h want 55", cap_byte_b); end
        checks++; if (cap_flags_b !== 3'b000) begin failures++; $display("FAIL par_ok_flags: got %b want 000", cap_flags_b); end
        bframe(7'h55, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (dvn_b - n0 !== 2) begin failures++; $display("FAIL par_bad_count: got %0d want 2", dvn_b - n0); end
        checks++; if (cap_flags_b !== 3'b100) begin failures++; $display("FAIL par_bad_flags: got %b want 100", cap_flags_b); end
        // 0x2A has three ones -> parity 1 is correct; only the second stop bit is bad.
        bframe(7'h2A, 1'b1, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        checks++; if (dvn_b - n0 !== 3) begin failures++; $display("FAIL stop2_count: got %0d want 3", dvn_b - n0); end
        checks++; if (cap_byte_b !== 7'h2A) begin failures++; $display("FAIL stop2_byte: got %h want 2a", cap_byte_b); end
        checks++; if (cap_flags_b !== 3'b010) begin failures++; $display("FAIL stop2_flags: got %b want 010", cap_flags_b); end
        checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL stop2_busy: got %b want 0", busy_b); end
    endtask

    task automatic test_break;
        int n0 = dvn_a;
        ser_a = 1'b0;
        repeat (50 * CPB) @(negedge clk);
        checks++; if (dvn_a - n0 !== 1) begin failures++; $display("FAIL brk_count: got %0d want 1", dvn_a - n0); end
        checks++; if (cap_byte_a !== 8'h00) begin failures++; $display("FAIL brk_byte: got %h want 00", cap_byte_a); end
        checks++; if (cap_flags_a !== 3'b011) begin failures++; $display("FAIL brk_flags: got %b want 011", cap_flags_a); end
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL brk_wait_busy: got %b want 1", busy_a); end
        ser_a = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL brk_release_busy: got %b want 0", busy_a); end
        aframe(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (dvn_a - n0 !== 2) begin failures++; $display("FAIL brk_next_count: got %0d want 2", dvn_a - n0); end
        checks++; if (cap_byte_a !== 8'h3C) begin failures++; $display("FAIL brk_next_byte: got %h want 3c", cap_byte_a); end
        checks++; if (cap_flags_a !== 3'b000) begin failures++; $display("FAIL brk_next_flags: got %b want 000", cap_flags_a); end
    endtask

    task automatic test_glitch;
        int n0 = dvn_a;
`ifdef UART_RX_MAJORITY_EN
        int glen = 6;
`else
        int glen = 8;
`endif
        ser_a = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL glitch_seen: got %b want 1", busy_a); end
        repeat (glen - 5) @(negedge clk);
        ser_a = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checks++; if (dvn_a - n0 !== 0) begin failures++; $display("FAIL glitch_dv: got %0d want 0", dvn_a - n0); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL glitch_idle: got %b want 0", busy_a); end
    endtask

    task automatic test_reset_midframe;
        int n0 = dvn_a;
        logic [7:0] d = 8'h5A;
        abit(1'b0);
        for (int i = 0; i < 4; i++) abit(d[i]);
        ser_a = d[4];
        repeat (8) @(negedge clk);
        rst_l = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", busy_a); end
        checks++; if ({byte_a, perr_a, fe_a, brk_a} !== 11'h000) begin failures++; $display("FAIL midrst_outputs: got %h want 000", {byte_a, perr_a, fe_a, brk_a}); end
        rst_l = 1'b1;
        ser_a = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checks++; if (dvn_a - n0 !== 0) begin failures++; $display("FAIL midrst_dv: got %0d want 0", dvn_a - n0); end
        aframe(8'h81, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (dvn_a - n0 !== 1) begin failures++; $display("FAIL midrst_next_count: got %0d want 1", dvn_a - n0); end
        checks++; if (cap_byte_a !== 8'h81) begin failures++; $display("FAIL midrst_next_byte: got %h want 81", cap_byte_a); end
    endtask

    task automatic test_back_to_back;
        int n0 = dvn_a;
        aframe(8'h12, 1'b1);
        aframe(8'h34, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (dvn_a - n0 !== 2) begin failures++; $display("FAIL b2b_count: got %0d want 2", dvn_a - n0); end
        if (q_a.size() >= 2) begin
            checks++; if (q_a[q_a.size()-2] !== 8'h12) begin failures++; $display("FAIL b2b_first: got %h want 12", q_a[q_a.size()-2]); end
            checks++; if (q_a[q_a.size()-1] !== 8'h34) begin failures++; $display("FAIL b2b_second: got %h want 34", q_a[q_a.size()-1]); end
        end else begin
            checks++; failures++; $display("FAIL b2b_queue: got %0d entries want 2", q_a.size());
        end
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_majority;
        int n0 = dvn_a;
        logic [7:0] d = 8'h0F;
        abit(1'b0);
        // One inverted cycle landing on each data sample point.
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < CPB; c++) begin
                ser_a = (c == 8) ? ~d[i] : d[i];
                @(negedge clk);
            end
        end
        abit(1'b1);
        repeat (4) @(negedge clk);
        checks++; if (dvn_a - n0 !== 1) begin failures++; $display("FAIL maj_count: got %0d want 1", dvn_a - n0); end
        checks++; if (cap_byte_a !== 8'h0F) begin failures++; $display("FAIL maj_byte: got %h want 0f", cap_byte_a); end
        checks++; if (cap_noise_a !== 1'b1) begin failures++; $display("FAIL maj_noise: got %b want 1", cap_noise_a); end
    endtask
`endif

    initial begin
        test_reset();
        test_8n1_basic();
        test_parity();
        test_break();
        test_glitch();
        test_reset_midframe();
        test_back_to_back();
`ifdef UART_RX_MAJORITY_EN
        test_majority();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
